ans_stream_decoder: RTL and testbench
=====================================

# ans_stream_decoder

Streaming rANS decoder, the inverse of the ANS encoder. It consumes the compressed nibble stream through a valid/ready input and emits 4-bit symbols through a valid/ready output. It uses the frequency table held by the table loader. It sits beside the encoder and loader inside the ANS core and is enabled when the core's command selects decode.

## Interface
Parameters:
- SYM_WIDTH, 4: symbol and stream-nibble width. The frequency table must sum to 2^SYM_WIDTH.
- STATE_WIDTH, 16: rANS state width. The lower bound is L = 2^(STATE_WIDTH-SYM_WIDTH) = 0x1000.
- CNT_WIDTH, 4: per-symbol count width. The table has 2^SYM_WIDTH entries.

Ports:
- clk  in  1  single clock; all flops on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  decode mode select. Low forces IDLE.
- counts_unpacked  in  64  count of symbol i at bits [4i+3:4i]. Must be stable while en is high.
- in  in  4  stream nibble.
- in_vld  in  1  stream nibble valid.
- in_rdy  out  1  decoder accepts a nibble this cycle.
- out  out  4  decoded symbol.
- out_vld  out  1  symbol valid.
- out_rdy  in  1  downstream accepts the symbol.
- err  out  1  sticky error flag. Cleared only by en low or reset.

## Operation
- The decoder consumes nibbles in reverse encoder order. The host reverses the stream. The first 4 nibbles form the initial state, most significant nibble first.
- Cumulative table: cum[s] is the sum of cnt[j] for j < s, computed combinationally from counts_unpacked. M is the sum of all counts. The table is valid only when M == 16.
- Symbol lookup: slot = x[3:0]. The decoded symbol s is the unique s with cum[s] <= slot < cum[s]+cnt[s]. Zero-count symbols never match.
- State update: x' = cnt[s]*(x>>4) + slot - cum[s]. This is 16 bits wide with no overflow, because 15*0xFFF + 15 < 2^16.
- Renormalisation: if x' < 0x1000, exactly one nibble is needed, x <= {x'[11:0], in}. Since cnt >= 1, x' >= 0x100, so one nibble always suffices.
- FSM states and transitions:
  - IDLE: if en is high, go to INIT with nib_cnt = 0.
  - INIT: in_rdy = 1. Each accepted nibble does x <= {x[11:0], in} and increments nib_cnt. After the 4th nibble: if M != 16 or the new x < 0x1000, go to ERR; otherwise go to DECODE.
  - DECODE: out_vld = 1 and out = lookup(x). On out_rdy, x <= x'. If x' < 0x1000, go to REFILL; otherwise stay in DECODE.
  - REFILL: in_rdy = 1. On in_vld, x <= {x'_held[11:0], in} and go to DECODE.
  - ERR: err = 1, in_rdy = 0, out_vld = 0.
- en low in any state: on the next edge the FSM goes to IDLE, x is cleared, and err is cleared. A new stream always restarts with INIT.
- The decoder runs until en drops. It does not count symbols; the host counts them.

## Timing
- Reset values: state IDLE, x = 0, nib_cnt = 0. Outputs: in_rdy = 0, out_vld = 0, out = 0, err = 0.
- All outputs decode from registered state. out depends on registered x and the static table. There is no combinational path from in_vld or out_rdy to any output.
- A transfer happens at the rising edge where vld & rdy are both high. The producer must hold the data until that edge.
- Latency:
  - The first symbol is valid on the cycle after the 4th init nibble is accepted.
  - Symbols with no refill issue at 1 per cycle under continuous out_rdy.
  - A refill costs 1 extra cycle at minimum.
- Backpressure: when out_rdy is low in DECODE, out and out_vld hold and x does not change.
- ERR is entered on the cycle after the 4th init nibble. err is high starting in that cycle.
- in_rdy and out_vld are never high in the same cycle.

## Structure
- Shared package ans_pkg holds:
  - SYM_WIDTH, STATE_WIDTH, CNT_WIDTH, SYM_COUNT, and the lower bound L = 0x1000;
  - the decoder FSM state encoding.
- Sub-module ans_sym_lookup, purely combinational:
  - input: counts_unpacked and slot;
  - outputs: sym, cnt_sel, cum_sel, and total M.
- The top-level decoder keeps the FSM, the x register, the held x', and nib_cnt.

## Test plan
- Uniform table (all counts 1), init nibbles 4,3,2,1 (x = 0x4321):
  - out = 1, x' = 0x432, REFILL;
  - feed 5 -> x = 0x4325, out = 5.
- Table cnt0=8, cnt1=4, cnt2=4, others 0, init x = 0xABCD:
  - out 2, x = 0x2AF1;
  - out 0, x = 0x1579;
  - out 1, x' = 0x55D, so in_rdy rises for a refill.
- Same stream with out_rdy low for 3 cycles on each symbol: out and out_vld hold, no nibble is consumed, and the symbol sequence is unchanged.
- Table summing to 15, or init x = 0x0FFF:
  - err = 1 after the 4th nibble, in_rdy = 0, out_vld = 0;
  - en low for 1 cycle -> err = 0, back in IDLE.
- Reset checks:
  - rst_n asserted mid-DECODE, asynchronously between edges: outputs go to reset values immediately;
  - after release with en high, INIT requires 4 fresh nibbles.
- Throughput check: no-refill symbols with out_rdy tied high produce one symbol per cycle.

Source files
------------

// File: rtl/ans_pkg.sv
// ans_pkg: shared rANS constants and decoder FSM encoding.
package ans_pkg;
    localparam int SYM_WIDTH   = 4;
    localparam int STATE_WIDTH = 16;
    localparam int CNT_WIDTH   = 4;
    localparam int SYM_COUNT   = 1 << SYM_WIDTH;
    localparam int SUM_WIDTH   = 8;
    localparam logic [STATE_WIDTH-1:0] L = STATE_WIDTH'(1) << (STATE_WIDTH - SYM_WIDTH);
    typedef enum logic [2:0] {IDLE, INIT, DECODE, REFILL, ERR} dec_state_t;
endpackage

// File: rtl/ans_stream_decoder_if.sv
// ans_stream_decoder_if: valid/ready nibble stream with producer and consumer views.
interface ans_stream_decoder_if #(parameter int W = 4);
    logic [W-1:0] data;
    logic         vld;
    logic         rdy;
    modport master(output data, vld, input rdy);
    modport slave(input data, vld, output rdy);
endinterface

// File: rtl/ans_sym_lookup.sv
// ans_sym_lookup: maps a state slot to its symbol, count and cumulative base.
module ans_sym_lookup import ans_pkg::*; (
    input  logic [CNT_WIDTH*SYM_COUNT-1:0] counts_unpacked,
    input  logic [SYM_WIDTH-1:0]           slot,
    output logic [SYM_WIDTH-1:0]           sym,
    output logic [CNT_WIDTH-1:0]           cnt_sel,
    output logic [SUM_WIDTH-1:0]           cum_sel,
    output logic [SUM_WIDTH-1:0]           total
);
    logic [CNT_WIDTH-1:0] c;
    // total doubles as the running cumulative sum; zero counts give an empty range
    always_comb begin
        sym = '0;
        cnt_sel = '0;
        cum_sel = '0;
        total = '0;
        c = '0;
        for (int i = 0; i < SYM_COUNT; i++) begin
            c = counts_unpacked[i*CNT_WIDTH +: CNT_WIDTH];
            if (SUM_WIDTH'(slot) >= total && SUM_WIDTH'(slot) < total + SUM_WIDTH'(c)) begin
                sym = SYM_WIDTH'(i);
                cnt_sel = c;
                cum_sel = total;
            end
            total = total + SUM_WIDTH'(c);
        end
    end
endmodule

// File: rtl/ans_stream_decoder.sv
// ans_stream_decoder: streaming rANS decoder, nibble stream in, 4-bit symbols out.
module ans_stream_decoder import ans_pkg::*; (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic [CNT_WIDTH*SYM_COUNT-1:0] counts_unpacked,
    ans_stream_decoder_if.slave            stream,
    ans_stream_decoder_if.master           symbols,
    output logic                           err
);
    dec_state_t state;
    logic [STATE_WIDTH-1:0] x, x_next, x_shift;
    logic [1:0] nib_cnt;
    logic [SYM_WIDTH-1:0] s;
    logic [CNT_WIDTH-1:0] cnt_sel;
    logic [SUM_WIDTH-1:0] cum_sel, total;
    ans_sym_lookup u_lookup (
        .counts_unpacked,
        .slot(x[SYM_WIDTH-1:0]),
        .sym(s),
        .cnt_sel,
        .cum_sel,
        .total
    );
    assign x_next = STATE_WIDTH'(cnt_sel) * (x >> SYM_WIDTH) + STATE_WIDTH'(x[SYM_WIDTH-1:0]) - STATE_WIDTH'(cum_sel);
    assign x_shift = {x[STATE_WIDTH-SYM_WIDTH-1:0], stream.data};
    assign stream.rdy = state == INIT || state == REFILL;
    assign symbols.vld = state == DECODE;
    assign symbols.data = state == DECODE ? s : '0;
    assign err = state == ERR;
    // during REFILL, x holds the undersized x' awaiting its one refill nibble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || !en) begin
            state <= IDLE;
            x <= '0;
            nib_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state <= INIT;
                    nib_cnt <= '0;
                end
                INIT: if (stream.vld) begin
                    x <= x_shift;
                    nib_cnt <= nib_cnt + 2'd1;
                    if (nib_cnt == 2'd3)
                        state <= (total != SUM_WIDTH'(SYM_COUNT) || x_shift < L) ? ERR : DECODE;
                end
                DECODE: if (symbols.rdy) begin
                    x <= x_next;
                    if (x_next < L) state <= REFILL;
                end
                REFILL: if (stream.vld) begin
                    x <= x_shift;
                    state <= DECODE;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ans_stream_decoder.sv
// tb_ans_stream_decoder: table vectors, corner sequences and randomized streams
// checked against an arithmetic rANS reference model.
module tb_ans_stream_decoder;
    logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, err;
    logic [63:0] counts = '0;
    int tests = 0, fails = 0;

    ans_stream_decoder_if stream_if ();
    ans_stream_decoder_if sym_if ();

    ans_stream_decoder dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .counts_unpacked(counts),
        .stream(stream_if.slave),
        .symbols(sym_if.master),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] c;
        logic [15:0] x0;
        logic        e;
        logic [3:0]  s;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int cnt_of(input logic [63:0] c, input int s);
        return int'(c[4*s +: 4]);
    endfunction

    // slot -> symbol by laying each symbol out cnt times in order
    function automatic int sym_at(input logic [63:0] c, input int slot);
        int idx = 0;
        for (int s = 0; s < 16; s++)
            for (int k = 0; k < cnt_of(c, s); k++) begin
                if (idx == slot) return s;
                idx++;
            end
        return -1;
    endfunction

    function automatic int cum_of(input logic [63:0] c, input int s);
        int t = 0;
        for (int j = 0; j < s; j++) t += cnt_of(c, j);
        return t;
    endfunction

    function automatic logic [15:0] step(input logic [63:0] c, input logic [15:0] x);
        int xi = int'(x);
        int s = sym_at(c, xi % 16);
        return 16'(cnt_of(c, s) * (xi / 16) + xi % 16 - cum_of(c, s));
    endfunction

    function automatic logic [63:0] rand_tbl();
        int cn[16];
        logic [63:0] r = '0;
        foreach (cn[i]) cn[i] = 0;
        for (int u = 0; u < 16;) begin
            int s;
            s = int'($urandom_range(15));
            if (cn[s] < 15) begin
                cn[s]++;
                u++;
            end
        end
        foreach (cn[i]) r[4*i +: 4] = 4'(cn[i]);
        return r;
    endfunction

    task automatic feed(input logic [3:0] n);
        int k = 0;
        stream_if.data = n;
        stream_if.vld = 1'b1;
        while (!stream_if.rdy && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("in_rdy_wait", int'(stream_if.rdy), 1);
        @(negedge clk);
        stream_if.vld = 1'b0;
    endtask

    task automatic take(input logic [3:0] exp, input string name);
        int k = 0;
        while (!sym_if.vld && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_vld"}, int'(sym_if.vld), 1);
        chk(name, int'(sym_if.data), int'(exp));
        sym_if.rdy = 1'b1;
        @(negedge clk);
        sym_if.rdy = 1'b0;
    endtask

    task automatic start(input logic [63:0] c, input logic [15:0] x0);
        en = 1'b0;
        @(negedge clk);
        counts = c;
        en = 1'b1;
        @(negedge clk);
        for (int i = 3; i >= 0; i--) feed(x0[4*i +: 4]);
    endtask

    task automatic run_rand(input logic [63:0] c, input logic [15:0] x0, input int nsym,
                            input int prdy, input int pvld);
        int ninit = 0, got = 0, cyc = 0;
        bit need = 0, ein, eout, v, r;
        logic [15:0] mx = '0;
        logic [3:0] d;
        en = 1'b0;
        @(negedge clk);
        counts = c;
        en = 1'b1;
        @(negedge clk);
        while (got < nsym && cyc < 40 * nsym + 100) begin
            ein = ninit < 4 || need;
            eout = ninit == 4 && !need;
            chk("rnd_in_rdy", int'(stream_if.rdy), int'(ein));
            chk("rnd_out_vld", int'(sym_if.vld), int'(eout));
            chk("rnd_err", int'(err), 0);
            if (eout) chk("rnd_sym", int'(sym_if.data), sym_at(c, int'(mx[3:0])));
            v = $urandom_range(99) < pvld;
            r = $urandom_range(99) < prdy;
            d = ninit < 4 ? x0[4*(3-ninit) +: 4] : 4'($urandom);
            stream_if.vld = v;
            stream_if.data = d;
            sym_if.rdy = r;
            if (ein && v) begin
                mx = {mx[11:0], d};
                if (ninit < 4) ninit++;
                else need = 0;
            end else if (eout && r) begin
                mx = step(c, mx);
                got++;
                need = mx < 16'h1000;
            end
            @(negedge clk);
            cyc++;
        end
        stream_if.vld = 1'b0;
        sym_if.rdy = 1'b0;
        chk("rnd_done", int'(got >= nsym), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[6];
        logic [3:0] eb[3];
        logic [63:0] uni = 64'h1111_1111_1111_1111;
        logic [63:0] tbl2 = 64'h0000_0000_0000_0448;
        logic [63:0] bad = 64'h0111_1111_1111_1111;
        vt[0] = '{uni, 16'h4321, 1'b0, 4'd1};
        vt[1] = '{tbl2, 16'hABCD, 1'b0, 4'd2};
        vt[2] = '{bad, 16'h4321, 1'b1, 4'd0};
        vt[3] = '{uni, 16'h0FFF, 1'b1, 4'd0};
        vt[4] = '{uni, 16'h1000, 1'b0, 4'd0};
        vt[5] = '{64'h0000_0000_1000_F000, 16'h8FFF, 1'b0, 4'd7};
        eb = '{4'd2, 4'd0, 4'd1};
        stream_if.vld = 1'b0;
        stream_if.data = '0;
        sym_if.rdy = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_rdy", int'(stream_if.rdy), 0);
        chk("rst_out_vld", int'(sym_if.vld), 0);
        chk("rst_out", int'(sym_if.data), 0);
        chk("rst_err", int'(err), 0);

        foreach (vt[i]) begin
            start(vt[i].c, vt[i].x0);
            chk("vec_err", int'(err), int'(vt[i].e));
            chk("vec_out_vld", int'(sym_if.vld), int'(!vt[i].e));
            chk("vec_in_rdy", int'(stream_if.rdy), 0);
            if (!vt[i].e) chk("vec_out", int'(sym_if.data), int'(vt[i].s));
        end

        // uniform table: first symbol forces a refill
        start(uni, 16'h4321);
        take(4'd1, "uni_sym0");
        chk("uni_refill_rdy", int'(stream_if.rdy), 1);
        chk("uni_refill_vld", int'(sym_if.vld), 0);
        feed(4'd5);
        chk("uni_sym1_vld", int'(sym_if.vld), 1);
        chk("uni_sym1", int'(sym_if.data), 5);

        // backpressure on every symbol of the 8/4/4 stream
        start(tbl2, 16'hABCD);
        foreach (eb[i]) begin
            sym_if.rdy = 1'b0;
            repeat (3) begin
                chk("bp_vld", int'(sym_if.vld), 1);
                chk("bp_sym", int'(sym_if.data), int'(eb[i]));
                chk("bp_in_rdy", int'(stream_if.rdy), 0);
                @(negedge clk);
            end
            take(eb[i], "bp_take");
        end
        chk("bp_refill_rdy", int'(stream_if.rdy), 1);
        chk("bp_refill_vld", int'(sym_if.vld), 0);

        // error is sticky until en drops
        start(bad, 16'h4321);
        stream_if.vld = 1'b1;
        repeat (2) @(negedge clk);
        chk("err_sticky", int'(err), 1);
        chk("err_in_rdy", int'(stream_if.rdy), 0);
        chk("err_out_vld", int'(sym_if.vld), 0);
        stream_if.vld = 1'b0;
        en = 1'b0;
        @(negedge clk);
        chk("err_clear", int'(err), 0);
        chk("idle_in_rdy", int'(stream_if.rdy), 0);
        chk("idle_out_vld", int'(sym_if.vld), 0);
        en = 1'b1;
        @(negedge clk);
        chk("reinit_rdy", int'(stream_if.rdy), 1);

        // asynchronous reset mid-DECODE, then a fresh 4-nibble init
        start(uni, 16'h4321);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_vld", int'(sym_if.vld), 0);
        chk("arst_out", int'(sym_if.data), 0);
        chk("arst_in_rdy", int'(stream_if.rdy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 2; i <= 4; i++) begin
            feed(4'(i));
            chk("arst_init_vld", int'(sym_if.vld), 0);
        end
        feed(4'd5);
        chk("arst_first_vld", int'(sym_if.vld), 1);
        chk("arst_first", int'(sym_if.data), 5);

        // full-rate throughput, then random tables and handshakes
        run_rand(64'h0000_0000_0000_001F, 16'hFFF0, 20, 100, 100);
        for (int r = 0; r < 6; r++)
            run_rand(rand_tbl(), 16'($urandom_range(16'hFFFF, 16'h1000)), 30,
                     r == 0 ? 100 : int'($urandom_range(100, 40)),
                     r == 0 ? 100 : int'($urandom_range(100, 40)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
